// File: rtl/golden_nonce_tx_queue_pkg.sv
// Shared widths and FSM encoding for the golden-nonce transmit queue.
package golden_nonce_tx_queue_pkg;

    localparam int unsigned NONCE_W         = 32;
    localparam int unsigned BYTES_PER_NONCE = 4;
    localparam int unsigned BYTE_W          = 8;
    localparam int unsigned BIDX_W          = $clog2(BYTES_PER_NONCE);
    localparam int unsigned DROP_W          = 8;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

endpackage

// File: rtl/golden_nonce_tx_queue_nonce_fifo.sv
// Synchronous nonce FIFO with registered count/full/empty; pushes while full are ignored.
module nonce_fifo
    import golden_nonce_tx_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic [NONCE_W-1:0] wdata,
    input  logic               pop,
    output logic [NONCE_W-1:0] rdata,
    output logic [AW:0]        count,
    output logic               full,
    output logic               empty
);

    logic [NONCE_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]        count_q, count_d;
    logic               full_q, full_d;
    logic               empty_q, empty_d;
    logic               do_push, do_pop;

    assign do_push = push & ~full_q;
    assign do_pop  = pop & ~empty_q;

    // Pointer and occupancy update; pointers wrap naturally since DEPTH is a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        full_d  = (count_d == (AW+1)'(DEPTH));
        empty_d = (count_d == '0);
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage array; contents are meaningless until written so it carries no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata;
    end

    assign rdata = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: rtl/golden_nonce_tx_queue.sv
// Buffers golden-nonce matches and streams each as a 4-byte LSB-first frame to the UART.
module golden_nonce_tx_queue
    import golden_nonce_tx_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic               hash_clk,
    input  logic               reset,
    input  logic [NONCE_W-1:0] golden_nonce_in,
    input  logic               golden_nonce_match,
    output logic [BYTE_W-1:0]  tx_data,
    output logic               tx_valid,
    input  logic               tx_ready,
    input  logic               clear_overflow,
    output logic [AW:0]        fifo_count,
    output logic               overflow,
    output logic [DROP_W-1:0]  dropped_count,
    output logic               busy
);

    state_e              state_q, state_d;
    logic [NONCE_W-1:0]  shreg_q, shreg_d;
    logic [BIDX_W-1:0]   byte_idx_q, byte_idx_d;
    logic                tx_valid_q, tx_valid_d;
    logic                overflow_q, overflow_d;
    logic [DROP_W-1:0]   dropped_q, dropped_d;
    logic                busy_q, busy_d;

    logic [NONCE_W-1:0]  fifo_rdata;
    logic                fifo_full, fifo_empty;
    logic                pop, drop, push_ok;
    logic [AW:0]         count_nxt;

    nonce_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk   (hash_clk),
        .reset (reset),
        .push  (golden_nonce_match),
        .wdata (golden_nonce_in),
        .pop   (pop),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign drop    = golden_nonce_match & fifo_full;
    assign push_ok = golden_nonce_match & ~fifo_full;

    // Frame FSM: load the head into the shift register, emit bytes, chain frames without a gap.
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        byte_idx_d = byte_idx_q;
        pop        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    shreg_d    = fifo_rdata;
                    byte_idx_d = '0;
                    state_d    = SEND;
                end
            end
            SEND: begin
                if (tx_ready) begin
                    if (byte_idx_q != BIDX_W'(BYTES_PER_NONCE - 1)) begin
                        shreg_d    = shreg_q >> BYTE_W;
                        byte_idx_d = byte_idx_q + BIDX_W'(1);
                    end else if (!fifo_empty) begin
                        pop        = 1'b1;
                        shreg_d    = fifo_rdata;
                        byte_idx_d = '0;
                    end else begin
                        state_d    = IDLE;
                    end
                end
            end
        endcase
        tx_valid_d = (state_d == SEND);
        count_nxt  = fifo_count + (AW+1)'(push_ok) - (AW+1)'(pop);
        busy_d     = (count_nxt != '0) || (state_d == SEND);
    end

    // Sticky overflow and saturating drop counter; a drop outranks a same-cycle clear.
    always_comb begin
        overflow_d = overflow_q;
        dropped_d  = dropped_q;
        if (drop) begin
            overflow_d = 1'b1;
            if (clear_overflow)        dropped_d = DROP_W'(1);
            else if (dropped_q != '1)  dropped_d = dropped_q + DROP_W'(1);
        end else if (clear_overflow) begin
            overflow_d = 1'b0;
            dropped_d  = '0;
        end
    end

    // State registers.
    always_ff @(posedge hash_clk) begin
        if (reset) begin
            state_q    <= IDLE;
            shreg_q    <= '0;
            byte_idx_q <= '0;
            tx_valid_q <= 1'b0;
            overflow_q <= 1'b0;
            dropped_q  <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            byte_idx_q <= byte_idx_d;
            tx_valid_q <= tx_valid_d;
            overflow_q <= overflow_d;
            dropped_q  <= dropped_d;
            busy_q     <= busy_d;
        end
    end

    assign tx_data       = shreg_q[BYTE_W-1:0];
    assign tx_valid      = tx_valid_q;
    assign overflow      = overflow_q;
    assign dropped_count = dropped_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_golden_nonce_tx_queue.sv
// Self-checking bench: directed vector table, corner-case sequences and a random run against a queue model.
module tb_golden_nonce_tx_queue;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned AW    = $clog2(DEPTH);

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] nonce;
    logic        match;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        clr;
    logic [AW:0] fifo_count;
    logic        overflow;
    logic [7:0]  dropped_count;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;

    golden_nonce_tx_queue #(.DEPTH(DEPTH)) dut (
        .hash_clk           (clk),
        .reset              (reset),
        .golden_nonce_in    (nonce),
        .golden_nonce_match (match),
        .tx_data            (tx_data),
        .tx_valid           (tx_valid),
        .tx_ready           (tx_ready),
        .clear_overflow     (clr),
        .fifo_count         (fifo_count),
        .overflow           (overflow),
        .dropped_count      (dropped_count),
        .busy               (busy)
    );

    always #5 clk = ~clk;

    // Reference model: queued nonces plus the frame currently on the wire.
    logic [31:0] mq[$];
    logic [31:0] m_cur;
    int          m_left;
    logic        m_ovf;
    int          m_drop;

    function automatic logic [7:0] m_byte();
        logic [31:0] v;
        v = m_cur >> (8 * (4 - m_left));
        return v[7:0];
    endfunction

    task automatic model_edge(input logic m, input logic [31:0] n, input logic rdy,
                              input logic c, input logic rs);
        bit full;
        bit do_pop;
        if (rs) begin
            mq.delete();
            m_left = 0;
            m_ovf  = 1'b0;
            m_drop = 0;
            return;
        end
        full   = (mq.size() == DEPTH);
        do_pop = 1'b0;
        if (m_left == 0) begin
            if (mq.size() > 0) do_pop = 1'b1;
        end else if (rdy) begin
            if (m_left == 1) begin
                if (mq.size() > 0) do_pop = 1'b1;
                else m_left = 0;
            end else begin
                m_left--;
            end
        end
        if (do_pop) begin
            m_cur  = mq.pop_front();
            m_left = 4;
        end
        if (m && full) begin
            m_ovf  = 1'b1;
            m_drop = c ? 1 : ((m_drop < 255) ? m_drop + 1 : 255);
        end else begin
            if (m) mq.push_back(n);
            if (c) begin
                m_ovf  = 1'b0;
                m_drop = 0;
            end
        end
    endtask

    task automatic chk(input string name, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, got, got, exp, exp);
        end
    endtask

    // One clock: drive inputs, advance the model, then compare DUT to model after the edge.
    task automatic step(input logic m, input logic [31:0] n, input logic rdy,
                        input logic c, input logic rs);
        bit ok;
        match = m; nonce = n; tx_ready = rdy; clr = c; reset = rs;
        model_edge(m, n, rdy, c, rs);
        @(posedge clk);
        #1;
        ok = (tx_valid == (m_left > 0)) &&
             (!(m_left > 0) || (tx_data == m_byte())) &&
             (int'(fifo_count) == mq.size()) &&
             (overflow == m_ovf) &&
             (int'(dropped_count) == m_drop) &&
             (busy == ((mq.size() > 0) || (m_left > 0)));
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL model @%0t: got v=%0b d=%02h cnt=%0d ovf=%0b drp=%0d busy=%0b, required v=%0b d=%02h cnt=%0d ovf=%0b drp=%0d busy=%0b",
                     $time, tx_valid, tx_data, fifo_count, overflow, dropped_count, busy,
                     (m_left > 0), m_byte(), mq.size(), m_ovf, m_drop, ((mq.size() > 0) || (m_left > 0)));
        end
    endtask

    typedef struct {
        logic        m;
        logic [31:0] n;
        logic        rdy;
        logic        rs;
        logic        ev;
        logic [7:0]  ed;
        int          ec;
        logic        eb;
    } vec_t;

    function automatic vec_t mk(logic m, logic [31:0] n, logic rdy, logic rs,
                                logic ev, logic [7:0] ed, int ec, logic eb);
        vec_t v;
        v.m = m; v.n = n; v.rdy = rdy; v.rs = rs;
        v.ev = ev; v.ed = ed; v.ec = ec; v.eb = eb;
        return v;
    endfunction

    vec_t tbl[18];

    initial begin
        logic [31:0] exp_n;
        logic [31:0] ex;
        int          d0;

        reset = 1'b1; match = 1'b0; nonce = '0; tx_ready = 1'b0; clr = 1'b0;
        m_left = 0; m_ovf = 1'b0; m_drop = 0; m_cur = '0;

        // Single nonce, then a frame with 5 cycles of backpressure on byte1.
        tbl[0]  = mk(0, 32'h0,        1, 1, 0, 8'h00, 0, 0);
        tbl[1]  = mk(1, 32'h12345678, 1, 0, 0, 8'h00, 1, 1);
        tbl[2]  = mk(0, 32'h0,        1, 0, 1, 8'h78, 0, 1);
        tbl[3]  = mk(0, 32'h0,        1, 0, 1, 8'h56, 0, 1);
        tbl[4]  = mk(0, 32'h0,        1, 0, 1, 8'h34, 0, 1);
        tbl[5]  = mk(0, 32'h0,        1, 0, 1, 8'h12, 0, 1);
        tbl[6]  = mk(0, 32'h0,        1, 0, 0, 8'h00, 0, 0);
        tbl[7]  = mk(1, 32'hAABBCCDD, 1, 0, 0, 8'h00, 1, 1);
        tbl[8]  = mk(0, 32'h0,        1, 0, 1, 8'hDD, 0, 1);
        tbl[9]  = mk(0, 32'h0,        1, 0, 1, 8'hCC, 0, 1);
        for (int i = 10; i < 15; i++) tbl[i] = mk(0, 32'h0, 0, 0, 1, 8'hCC, 0, 1);
        tbl[15] = mk(0, 32'h0,        1, 0, 1, 8'hBB, 0, 1);
        tbl[16] = mk(0, 32'h0,        1, 0, 1, 8'hAA, 0, 1);
        tbl[17] = mk(0, 32'h0,        1, 0, 0, 8'h00, 0, 0);

        for (int i = 0; i < 18; i++) begin
            step(tbl[i].m, tbl[i].n, tbl[i].rdy, 1'b0, tbl[i].rs);
            chk($sformatf("tbl%0d.valid", i), int'(tx_valid), int'(tbl[i].ev));
            if (tbl[i].ev) chk($sformatf("tbl%0d.data", i), int'(tx_data), int'(tbl[i].ed));
            chk($sformatf("tbl%0d.count", i), int'(fifo_count), tbl[i].ec);
            chk($sformatf("tbl%0d.busy", i), int'(busy), int'(tbl[i].eb));
            chk($sformatf("tbl%0d.ovf", i), int'(overflow), 0);
        end

        // Overflow: 10 strobes under backpressure, then 36 gapless bytes for nonces 1..9.
        step(0, 0, 0, 0, 1);
        for (int i = 1; i <= 10; i++) step(1, 32'(i), 0, 0, 0);
        chk("ovf.count", int'(fifo_count), 8);
        chk("ovf.flag", int'(overflow), 1);
        chk("ovf.dropped", int'(dropped_count), 1);
        chk("ovf.head", int'(tx_data), 1);
        for (int k = 0; k < 36; k++) begin
            exp_n = 32'(k / 4 + 1);
            ex    = exp_n >> (8 * (k % 4));
            chk($sformatf("ovf.byte%0d.valid", k), int'(tx_valid), 1);
            chk($sformatf("ovf.byte%0d.data", k), int'(tx_data), int'(ex[7:0]));
            step(0, 0, 1, 0, 0);
        end
        chk("ovf.drained", int'(tx_valid), 0);
        chk("ovf.idle", int'(busy), 0);

        // Push on the same edge as a frame-final pop while full: push is dropped.
        step(0, 0, 0, 0, 1);
        step(1, 32'hA0A0A0A0, 0, 0, 0);
        for (int i = 1; i <= 8; i++) step(1, 32'hB0 + 32'(i), 0, 0, 0);
        chk("pp.full", int'(fifo_count), 8);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);
        d0 = int'(dropped_count);
        step(1, 32'hDEADBEEF, 1, 0, 0);
        chk("pp.count", int'(fifo_count), 7);
        chk("pp.dropped", int'(dropped_count), d0 + 1);
        chk("pp.next", int'(tx_data), 8'hB1);

        // Reset mid-frame with entries queued, then a fresh frame.
        step(0, 0, 0, 0, 1);
        step(1, 32'hAABBCCDD, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, 32'h100 + 32'(i), 0, 0, 0);
        chk("rst.queued", int'(fifo_count), 3);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        chk("rst.byte2", int'(tx_data), 8'hBB);
        step(0, 0, 1, 0, 1);
        chk("rst.valid", int'(tx_valid), 0);
        chk("rst.count", int'(fifo_count), 0);
        chk("rst.ovf", int'(overflow), 0);
        step(1, 32'h00000001, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        chk("rst.b0", int'(tx_data), 8'h01);
        for (int i = 1; i < 4; i++) begin
            step(0, 0, 1, 0, 0);
            chk($sformatf("rst.b%0d", i), int'(tx_data), 0);
            chk($sformatf("rst.v%0d", i), int'(tx_valid), 1);
        end
        step(0, 0, 1, 0, 0);
        chk("rst.done", int'(tx_valid), 0);

        // Saturation and clear precedence.
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 9; i++) step(1, 32'h200 + 32'(i), 0, 0, 0);
        for (int i = 0; i < 300; i++) step(1, 32'h300 + 32'(i), 0, 0, 0);
        chk("sat.count", int'(dropped_count), 255);
        chk("sat.flag", int'(overflow), 1);
        step(0, 0, 0, 1, 0);
        chk("clr.flag", int'(overflow), 0);
        chk("clr.count", int'(dropped_count), 0);
        step(1, 32'h400, 0, 1, 0);
        chk("clrdrop.flag", int'(overflow), 1);
        chk("clrdrop.count", int'(dropped_count), 1);

        // Random traffic against the model.
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 4000; i++) begin
            step(($urandom_range(99) < 40), $urandom, ($urandom_range(99) < 55),
                 ($urandom_range(99) < 3), ($urandom_range(999) < 4));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/golden_nonce_tx_queue.md
Name: golden_nonce_tx_queue

Overview:
- Sits directly downstream of the hashing core.
- Captures each golden-nonce match strobe and its 32-bit nonce into a small FIFO.
- Drains the FIFO as 4-byte frames, LSB first, over a valid/ready byte handshake to the serial (UART) transmitter.
- Purpose: no match is lost while the serial link is busy; overflow is reported when it is.

Parameters:
- DEPTH, 8, FIFO entries; power of two, 2..64.
- AW, $clog2(DEPTH), FIFO address width (derived; do not override).

Ports:
- hash_clk  input  1  single clock; all logic on posedge.
- reset  input  1  synchronous, active-high; one clock, reset is synchronous and active-high.
- golden_nonce_in  input  32  nonce from hashing core; valid only when golden_nonce_match=1.
- golden_nonce_match  input  1  one-cycle push strobe.
- tx_data  output  8  byte to transmitter.
- tx_valid  output  1  tx_data valid.
- tx_ready  input  1  transmitter accepts byte this cycle (transfer = tx_valid & tx_ready).
- clear_overflow  input  1  clears overflow and dropped_count.
- fifo_count  output  AW+1  entries currently stored (0..DEPTH).
- overflow  output  1  sticky: at least one match dropped.
- dropped_count  output  8  saturating count of dropped matches.
- busy  output  1  fifo_count!=0 or frame in progress.

Behaviour:
- Reset values:
  - tx_valid=0, tx_data=0, fifo_count=0, overflow=0, dropped_count=0, busy=0.
  - FIFO pointers=0, FSM=IDLE.
- Reset mid-frame: the frame is abandoned and FIFO contents are discarded. tx_valid=0 from the cycle after the reset edge. No partial-frame resume.
- Push: on an edge with golden_nonce_match=1 and fifo_count<DEPTH, write golden_nonce_in at wr_ptr; wr_ptr++ (wraps mod DEPTH).
- Full:
  - A push with fifo_count==DEPTH is dropped, even if a pop occurs the same cycle.
  - On a drop: overflow<=1; dropped_count<=dropped_count+1, saturating at 255.
- clear_overflow:
  - Clears overflow and dropped_count.
  - If it coincides with a drop, the drop wins: overflow=1, dropped_count=1.
- Pop: performed only by the FSM; rd_ptr++ (wraps mod DEPTH).
- Simultaneous push and pop (not full): fifo_count unchanged and both pointers advance.
- fifo_count is registered and reflects the post-edge state.
- FSM states:
  - IDLE: tx_valid=0. If fifo_count!=0: pop the head into a 32-bit shift register, byte_idx<=0, go SEND.
  - SEND: tx_valid=1, tx_data=shreg[7:0].
    - On transfer with byte_idx<3: shreg>>=8, byte_idx++.
    - On transfer with byte_idx==3 and fifo_count!=0: pop the next entry directly into shreg, byte_idx<=0, stay in SEND. Back-to-back frames have no idle gap.
    - On transfer with byte_idx==3 and FIFO empty: go IDLE.
- Handshake rules:
  - tx_data and tx_valid are held stable while tx_valid & !tx_ready.
  - tx_valid never drops mid-frame except on reset.
- Latency, empty queue: a strobe at edge N gives fifo_count=1 after edge N. Pop at edge N+1; tx_valid=1 with byte0 after edge N+1, i.e. visible in the cycle following edge N+1.
- Frame byte order: nonce[7:0], [15:8], [23:16], [31:24].
- Ordering: strict FIFO; no reordering or duplication.
- The shift register holds the in-flight frame. A frame in flight does not count toward fifo_count, so effective buffering is DEPTH+1.

Decomposition:
- Shared package holds:
  - NONCE_W=32
  - BYTES_PER_NONCE=4
  - FSM state enum {IDLE, SEND}
- One sub-module: nonce_fifo.
  - Parameterised synchronous FIFO: DEPTH, width 32, registered count, full/empty.
  - Drop on full is handled internally; the parent computes drop = match & full.
- The FSM, shift register and overflow/drop counters stay in golden_nonce_tx_queue.

Test Plan:
1. Single nonce: match with 0x12345678, tx_ready=1 → bytes 0x78,0x56,0x34,0x12 on four consecutive cycles, starting the cycle after the pop edge. Then tx_valid=0, busy=0.
2. Backpressure: tx_ready=0 for 5 cycles mid-frame at byte1 → tx_data holds 0x56 and tx_valid stays 1. Resumes on tx_ready=1; no byte lost or repeated.
3. Overflow (DEPTH=8): tx_ready=0, 10 strobes with nonces 1..10.
   - Expect: nonce 1 in the shift register, fifo_count=8, overflow=1, dropped_count=1; nonce 10 is dropped.
   - Release tx_ready: nonces 1..9 emitted in order, back-to-back, 36 bytes without gap.
4. Simultaneous push/pop at full: a strobe arrives on the same edge as a frame-final pop with fifo_count==8 → push dropped, fifo_count=7, dropped_count increments.
5. Reset mid-frame: reset asserted after byte1 of 0xAABBCCDD with 3 entries queued → next cycle tx_valid=0, fifo_count=0, overflow=0. A new match 0x00000001 then emits 0x01,0x00,0x00,0x00.
6. Saturation/clear: 300 drops → dropped_count=255. clear_overflow on a non-drop cycle → 0/0. clear_overflow coincident with a drop → overflow=1, count=1.
